// File: rtl/vrf_pkg.sv
// Shared definitions for the vector register file.
// Holds the default vector geometry and the element type used by the
// storage banks and by anything that talks to the register file.
package vrf_pkg;

  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned ELEM_W_DEF = 8;

  // One vector element at the default element width.
  typedef logic [ELEM_W_DEF-1:0] elem_t;

endpackage : vrf_pkg

// File: rtl/vrf_lane_bank.sv
// One lane slice of the vector register file: REG_QTY elements of ELEM_W
// bits, one write port and two combinational read ports.
// Optional feature: define VRF_BYPASS_EN to forward the write data onto a
// read port that selects the register being written in the same cycle.
module vrf_lane_bank
  import vrf_pkg::*;
#(
  parameter int unsigned REG_QTY  = 8,
  parameter int unsigned ELEM_W   = ELEM_W_DEF,
  parameter int unsigned SEL_W    = $clog2(REG_QTY),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [ELEM_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  rd_sel1,
  input  logic [SEL_W-1:0]  rd_sel2,
  output logic [ELEM_W-1:0] rd_data1,
  output logic [ELEM_W-1:0] rd_data2
);

  logic [ELEM_W-1:0] mem_q [REG_QTY];
  logic              wr_ok;

  // Qualify the write: register 0 is read-only when it is the zero register.
  always_comb begin
    wr_ok = wr_en;
    if ((ZERO_REG != 0) && (wr_sel == '0)) begin
      wr_ok = 1'b0;
    end
  end

  // Element storage with synchronous clear of every entry.
  // NOTE: the array is reset because a cleared register file is part of the
  // architectural reset state; this keeps it out of plain RAM macros.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < int'(REG_QTY); r++) begin
        mem_q[r] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_sel] <= wr_data;
    end
  end

  // Combinational read ports with zero-register masking and optional bypass.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    rd_data1 = mem_q[rd_sel1];
    rd_data2 = mem_q[rd_sel2];
    if ((ZERO_REG != 0) && (rd_sel1 == '0)) rd_data1 = '0;
    if ((ZERO_REG != 0) && (rd_sel2 == '0)) rd_data2 = '0;
`ifdef VRF_BYPASS_EN
    // wr_ok already excludes the zero register, so r0 is never forwarded.
    if (wr_ok && (rd_sel1 == wr_sel)) rd_data1 = wr_data;
    if (wr_ok && (rd_sel2 == wr_sel)) rd_data2 = wr_data;
`else
    // Without forwarding a read in the write cycle returns the old contents.
`endif
  end

endmodule : vrf_lane_bank

// File: rtl/vector_register_file.sv
// Vector register file with per-lane write masking, two read ports and a
// busy scoreboard for tracking registers with an outstanding producer.
// Optional feature: define VRF_BYPASS_EN for same-cycle write-to-read
// forwarding (implemented inside vrf_lane_bank).
module vector_register_file
  import vrf_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned ELEM_W   = ELEM_W_DEF,
  parameter int unsigned REG_QTY  = 8,
  parameter int unsigned SEL_W    = $clog2(REG_QTY),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    regWrEn,
  input  logic [SEL_W-1:0]        regToWrite,
  input  logic [LANES-1:0]        laneMask,
  input  logic [LANES*ELEM_W-1:0] dataIn,
  input  logic [SEL_W-1:0]        rSel1,
  input  logic [SEL_W-1:0]        rSel2,
  output logic [LANES*ELEM_W-1:0] reg1Out,
  output logic [LANES*ELEM_W-1:0] reg2Out,
  input  logic                    reserveEn,
  input  logic [SEL_W-1:0]        reserveSel,
  output logic                    busy1,
  output logic                    busy2,
  output logic                    reserveErr
);

  // ---------------------------------------------------------------------
  // Storage: one bank per lane, each written only when its mask bit is set.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    vrf_lane_bank #(
      .REG_QTY  (REG_QTY),
      .ELEM_W   (ELEM_W),
      .SEL_W    (SEL_W),
      .ZERO_REG (ZERO_REG)
    ) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (regWrEn & laneMask[i]),
      .wr_sel   (regToWrite),
      .wr_data  (dataIn[i*ELEM_W +: ELEM_W]),
      .rd_sel1  (rSel1),
      .rd_sel2  (rSel2),
      .rd_data1 (reg1Out[i*ELEM_W +: ELEM_W]),
      .rd_data2 (reg2Out[i*ELEM_W +: ELEM_W])
    );
  end

  // ---------------------------------------------------------------------
  // Busy scoreboard and reserve-error flag.
  // ---------------------------------------------------------------------
  logic [REG_QTY-1:0] busy_q, busy_d;
  logic               err_q, err_d;
  logic               res_zero;
  logic               res_hits_write;

  assign res_zero       = (ZERO_REG != 0) && (reserveSel == '0);
  assign res_hits_write = regWrEn && (regToWrite == reserveSel);

  // Next busy state: a write retires the producer, a reserve (applied last so
  // it wins on a collision) marks a new one; r0 never goes busy.
  always_comb begin
    busy_d = busy_q;
    if (regWrEn) busy_d[regToWrite] = 1'b0;
    if (reserveEn && !res_zero) busy_d[reserveSel] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;

    // Reserving a register that is still busy is an error, unless the same
    // cycle's write retires the old producer.
    err_d = reserveEn && !res_zero && busy_q[reserveSel] && !res_hits_write;
  end

  // Scoreboard state register with synchronous active-low reset.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy1      = busy_q[rSel1];
  assign busy2      = busy_q[rSel2];
  assign reserveErr = err_q;

endmodule : vector_register_file

// File: tb/tb_vector_register_file.sv
// Directed self-checking bench for vector_register_file at default
// parameters (4 lanes x 8 bits, 8 registers, register 0 hardwired to zero).
module tb_vector_register_file;

  localparam int LANES  = 4;
  localparam int ELEM_W = 8;
  localparam int SEL_W  = 3;
  localparam int VW     = LANES * ELEM_W;

  logic             clk;
  logic             reset;
  logic             regWrEn;
  logic [SEL_W-1:0] regToWrite;
  logic [LANES-1:0] laneMask;
  logic [VW-1:0]    dataIn;
  logic [SEL_W-1:0] rSel1, rSel2;
  logic [VW-1:0]    reg1Out, reg2Out;
  logic             reserveEn;
  logic [SEL_W-1:0] reserveSel;
  logic             busy1, busy2;
  logic             reserveErr;

  int checks = 0;
  int errors = 0;

  vector_register_file dut (
    .clk        (clk),
    .reset      (reset),
    .regWrEn    (regWrEn),
    .regToWrite (regToWrite),
    .laneMask   (laneMask),
    .dataIn     (dataIn),
    .rSel1      (rSel1),
    .rSel2      (rSel2),
    .reg1Out    (reg1Out),
    .reg2Out    (reg2Out),
    .reserveEn  (reserveEn),
    .reserveSel (reserveSel),
    .busy1      (busy1),
    .busy2      (busy2),
    .reserveErr (reserveErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [VW-1:0] obs,
                       input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled
  // 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrEn    = 1'b0;
    regToWrite = '0;
    laneMask   = '0;
    dataIn     = '0;
    reserveEn  = 1'b0;
    reserveSel = '0;
  endtask

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    rSel1 = '0;
    rSel2 = '0;
    idle();
    tick();
    tick();
    reset = 1'b1;

    // Reset state.
    rSel1 = 3'd3; rSel2 = 3'd7;
    #1;
    check("rst_reg1", reg1Out, 32'h0);
    check("rst_reg2", reg2Out, 32'h0);
    check("rst_busy1", {31'b0, busy1}, 32'h0);
    check("rst_busy2", {31'b0, busy2}, 32'h0);
    check("rst_err", {31'b0, reserveErr}, 32'h0);

    // Full write then partial write to r3.
    regWrEn = 1'b1; regToWrite = 3'd3; laneMask = 4'b1111; dataIn = 32'h44332211;
    tick();
    dataIn = 32'hAABBCCDD; laneMask = 4'b0101;
    tick();
    idle();
    rSel1 = 3'd3; rSel2 = 3'd3;
    #1;
    check("mask_r3_p1", reg1Out, 32'h44BB22DD);
    check("mask_r3_p2", reg2Out, 32'h44BB22DD);
    check("mask_r3_busy", {31'b0, busy1}, 32'h0);

    // Upper/odd lanes only to r6; the other read port keeps showing r3.
    regWrEn = 1'b1; regToWrite = 3'd6; laneMask = 4'b1010; dataIn = 32'h12345678;
    tick();
    idle();
    rSel2 = 3'd6;
    #1;
    check("mask_r6", reg2Out, 32'h12005600);
    check("indep_r3", reg1Out, 32'h44BB22DD);

    // Write and reserve r0: stays zero and never busy.
    regWrEn = 1'b1; regToWrite = 3'd0; laneMask = 4'b1111; dataIn = 32'hFFFFFFFF;
    reserveEn = 1'b1; reserveSel = 3'd0;
    rSel1 = 3'd0;
    #1;
    check("r0_same_cycle", reg1Out, 32'h0);
    tick();
    tick();
    idle();
    #1;
    check("r0_read", reg1Out, 32'h0);
    check("r0_busy", {31'b0, busy1}, 32'h0);
    check("r0_err", {31'b0, reserveErr}, 32'h0);

    // Double reserve of r5.
    rSel1 = 3'd5;
    reserveEn = 1'b1; reserveSel = 3'd5;
    tick();
    check("r5_busy_a", {31'b0, busy1}, 32'h1);
    check("r5_err_a", {31'b0, reserveErr}, 32'h0);
    tick();
    idle();
    check("r5_busy_b", {31'b0, busy1}, 32'h1);
    check("r5_err_b", {31'b0, reserveErr}, 32'h1);
    tick();
    check("r5_err_pulse", {31'b0, reserveErr}, 32'h0);
    check("r5_busy_c", {31'b0, busy1}, 32'h1);
    // Masked-off write: no data change, but busy clears.
    regWrEn = 1'b1; regToWrite = 3'd5; laneMask = 4'b0000; dataIn = 32'hDEADBEEF;
    tick();
    idle();
    check("r5_busy_clr", {31'b0, busy1}, 32'h0);
    check("r5_nomask_data", reg1Out, 32'h0);

    // Reserve and write r2 together: reserve wins, no error, data lands.
    rSel2 = 3'd2;
    reserveEn = 1'b1; reserveSel = 3'd2;
    regWrEn = 1'b1; regToWrite = 3'd2; laneMask = 4'b1111; dataIn = 32'h01020304;
    tick();
    check("r2_busy", {31'b0, busy2}, 32'h1);
    check("r2_err", {31'b0, reserveErr}, 32'h0);
    check("r2_data", reg2Out, 32'h01020304);
    // Same again while already busy: still no error.
    tick();
    check("r2_busy_again", {31'b0, busy2}, 32'h1);
    check("r2_err_again", {31'b0, reserveErr}, 32'h0);
    idle();
    regWrEn = 1'b1; regToWrite = 3'd2; laneMask = 4'b0000;
    tick();
    idle();
    check("r2_busy_clr", {31'b0, busy2}, 32'h0);

    // Read of r1 during its own write cycle.
    rSel1 = 3'd1;
    regWrEn = 1'b1; regToWrite = 3'd1; laneMask = 4'b0011; dataIn = 32'h11223344;
    #1;
`ifdef VRF_BYPASS_EN
    check("r1_write_cycle", reg1Out, 32'h00003344);
`else
    check("r1_write_cycle", reg1Out, 32'h00000000);
`endif
    tick();
    idle();
    check("r1_next_cycle", reg1Out, 32'h00003344);

    // Load r4 and make it busy, then reset collides with a write and reserve.
    rSel1 = 3'd4;
    regWrEn = 1'b1; regToWrite = 3'd4; laneMask = 4'b1111; dataIn = 32'h00000055;
    reserveEn = 1'b1; reserveSel = 3'd4;
    tick();
    check("r4_loaded", reg1Out, 32'h00000055);
    check("r4_busy", {31'b0, busy1}, 32'h1);
    reset = 1'b0;
    regWrEn = 1'b1; regToWrite = 3'd4; laneMask = 4'b1111; dataIn = 32'h99999999;
    reserveEn = 1'b1; reserveSel = 3'd7;
    tick();
    reset = 1'b1;
    idle();
    rSel2 = 3'd7;
    #1;
    check("rst_r4_data", reg1Out, 32'h0);
    check("rst_r4_busy", {31'b0, busy1}, 32'h0);
    check("rst_r7_busy", {31'b0, busy2}, 32'h0);
    rSel2 = 3'd3;
    #1;
    check("rst_r3_data", reg2Out, 32'h0);
    check("rst_err_after", {31'b0, reserveErr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vector_register_file
